// File: rtl/regfile_wb_arb.sv
// ---------------------------------------------------------------------------
// regfile_wb_arb
//   Two-requester round-robin write arbiter in front of a register file.
//   Accepted requests appear on the write port one cycle after acceptance.
//   An optional zero-fill sweep clears every register after reset; it is
//   compiled in only when REGWB_INIT_SWEEP_EN is defined. The default build
//   (macro undefined) has no sweep and starts arbitrating at reset release.
//
// Parameters
//   DATA_W      register data width
//   ADDR_W      register address width (2**ADDR_W registers)
//
// Ports
//   CLK                    clock, all state changes on posedge
//   CLR                    asynchronous active-high reset
//   req0_valid/req1_valid  write request from requester 0 / 1
//   req0_addr /req1_addr   target register
//   req0_data /req1_data   write data
//   req0_ready/req1_ready  request accepted this cycle (combinational)
//   wr_E                   register-file write enable (registered)
//   wr_addr                register-file write address (registered)
//   din                    register-file write data (registered)
//   busy                   high while the init sweep runs
// ---------------------------------------------------------------------------
module regfile_wb_arb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              wr_E,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] din,
  output logic              busy
);

  logic              wr_e_q,    wr_e_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] din_q,     din_d;
  // rr_ptr selects the winner when both requesters are valid (0 -> req0).
  logic              rr_ptr_q,  rr_ptr_d;
  logic              run;
  logic              grant0, grant1;

`ifdef REGWB_INIT_SWEEP_EN
  typedef enum logic {SWEEP, RUN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_cnt_q, sweep_cnt_d;

  assign run  = (state_q == RUN);
  assign busy = (state_q == SWEEP);
`else
  assign run  = 1'b1;
  assign busy = 1'b0;
`endif

  // Readies depend only on valids, state and rr_ptr, never on each other,
  // so at most one request is accepted per cycle.
  assign grant0 = run && req0_valid && (!req1_valid || !rr_ptr_q);
  assign grant1 = run && req1_valid && (!req0_valid ||  rr_ptr_q);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    wr_e_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    din_d     = din_q;
    rr_ptr_d  = rr_ptr_q;
`ifdef REGWB_INIT_SWEEP_EN
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
`endif

    if (grant0) begin
      wr_e_d    = 1'b1;
      wr_addr_d = req0_addr;
      din_d     = req0_data;
      rr_ptr_d  = 1'b1;          // the other requester wins the next tie
    end else if (grant1) begin
      wr_e_d    = 1'b1;
      wr_addr_d = req1_addr;
      din_d     = req1_data;
      rr_ptr_d  = 1'b0;
    end

`ifdef REGWB_INIT_SWEEP_EN
    // Grants are forced low in SWEEP, so this never overrides a transfer.
    if (state_q == SWEEP) begin
      wr_e_d      = 1'b1;
      wr_addr_d   = sweep_cnt_q;
      din_d       = '0;
      sweep_cnt_d = sweep_cnt_q + 1'b1;
      // Leave SWEEP on the same edge that issues the last address.
      if (sweep_cnt_q == '1) state_d = RUN;
    end
`endif
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      wr_e_q      <= 1'b0;
      wr_addr_q   <= '0;
      din_q       <= '0;
      rr_ptr_q    <= 1'b0;
`ifdef REGWB_INIT_SWEEP_EN
      state_q     <= SWEEP;
      sweep_cnt_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      wr_e_q      <= wr_e_d;
      wr_addr_q   <= wr_addr_d;
      din_q       <= din_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef REGWB_INIT_SWEEP_EN
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
`endif
    end
  end

  assign wr_E    = wr_e_q;
  assign wr_addr = wr_addr_q;
  assign din     = din_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arb
//   Directed self-checking bench for regfile_wb_arb (DATA_W=16, ADDR_W=3).
//   A behavioural register file sits on the write port so stored contents
//   can be compared after each scenario. Sweep scenarios are compiled only
//   when REGWB_INIT_SWEEP_EN is defined, matching the DUT build.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic              CLK = 1'b0;
  logic              CLR = 1'b1;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0,    req1_addr = '0;
  logic [DATA_W-1:0] req0_data = '0,    req1_data = '0;
  logic              req0_ready, req1_ready;
  logic              wr_E;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] din;
  logic              busy;

  int n_total = 0;
  int n_bad   = 0;

  logic [DATA_W-1:0] rf [2**ADDR_W];

  regfile_wb_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .wr_E       (wr_E),
    .wr_addr    (wr_addr),
    .din        (din),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // Register file model: writes on the edge after wr_E is presented.
  initial for (int i = 0; i < 2**ADDR_W; i++) rf[i] = 16'hDEAD;
  always @(posedge CLK) if (wr_E) rf[wr_addr] <= din;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests at the negedge, check readies, then step
  // past the posedge so registered outputs can be inspected by the caller.
  task automatic step(input logic v0, input logic [ADDR_W-1:0] a0,
                      input logic [DATA_W-1:0] d0,
                      input logic v1, input logic [ADDR_W-1:0] a1,
                      input logic [DATA_W-1:0] d1,
                      input logic exp_r0, input logic exp_r1,
                      input string tag);
    @(negedge CLK);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    check({tag, " ready0"}, req0_ready, exp_r0);
    check({tag, " ready1"}, req1_ready, exp_r1);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, tag);
  endtask

  task automatic check_wr(input string tag, input logic e,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    check({tag, " wr_E"},    wr_E,    e);
    check({tag, " wr_addr"}, wr_addr, a);
    check({tag, " din"},     din,     d);
  endtask

`ifdef REGWB_INIT_SWEEP_EN
  // Eight consecutive zero writes; busy drops on the edge issuing address 7.
  task automatic check_sweep(input string tag);
    for (int k = 0; k < 2**ADDR_W; k++) begin
      @(posedge CLK); #1;
      check_wr(tag, 1'b1, ADDR_W'(k), 16'h0000);
      check({tag, " busy"}, busy, (k < 2**ADDR_W - 1));
    end
    @(posedge CLK); #1;
    check({tag, " end wr_E"}, wr_E, 1'b0);
    check({tag, " end busy"}, busy, 1'b0);
  endtask
`endif

  logic exp_busy_rst;
  logic exp_ready_after;
  logic [DATA_W-1:0] exp_r4;

  initial begin
`ifdef REGWB_INIT_SWEEP_EN
    exp_busy_rst    = 1'b1;
    exp_ready_after = 1'b0;
    exp_r4          = 16'h0000;
`else
    exp_busy_rst    = 1'b0;
    exp_ready_after = 1'b1;
    exp_r4          = 16'hDEAD;
`endif

    // Reset state
    #3;
    check_wr("reset", 1'b0, 3'd0, 16'h0000);
    check("reset busy", busy, exp_busy_rst);
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;

`ifdef REGWB_INIT_SWEEP_EN
    check("sweep start busy", busy, 1'b1);
    check_sweep("sweep");

    // Reset mid-sweep: abort when address 4 is presented, then restart.
    @(negedge CLK); CLR = 1'b1;
    @(negedge CLK); CLR = 1'b0;
    for (int k = 0; k < 5; k++) begin @(posedge CLK); #1; end
    check("midsweep addr", wr_addr, 3'd4);
    #1 CLR = 1'b1;
    #1;
    check_wr("midsweep clr", 1'b0, 3'd0, 16'h0000);
    check("midsweep clr busy", busy, 1'b1);
    @(negedge CLK); CLR = 1'b0;
    check_sweep("resweep");
`endif

    // Contention from reset: rr_ptr=0 so req0 first, then req1.
    step(1'b1, 3'd1, 16'hA000, 1'b1, 3'd2, 16'hB000, 1'b1, 1'b0, "cont c0");
    check_wr("cont c0", 1'b1, 3'd1, 16'hA000);
    step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'hB000, 1'b0, 1'b1, "cont c1");
    check_wr("cont c1", 1'b1, 3'd2, 16'hB000);
    idle("cont idle");
    check_wr("cont idle", 1'b0, 3'd2, 16'hB000);
    check("cont R1", rf[1], 16'hA000);
    check("cont R2", rf[2], 16'hB000);

    // Single requester: same-cycle ready, write one cycle later.
    step(1'b1, 3'd3, 16'h0123, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, "single");
    check_wr("single", 1'b1, 3'd3, 16'h0123);
    idle("single idle");
    check("single R3", rf[3], 16'h0123);

    // rr_ptr is 1 now; a lone req1 transfer moves it back to 0.
    step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h0666, 1'b0, 1'b1, "req1 only");
    check_wr("req1 only", 1'b1, 3'd6, 16'h0666);

    // Same-address collision: 1111 then 2222, 2222 persists.
    step(1'b1, 3'd5, 16'h1111, 1'b1, 3'd5, 16'h2222, 1'b1, 1'b0, "coll c0");
    check_wr("coll c0", 1'b1, 3'd5, 16'h1111);
    step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h2222, 1'b0, 1'b1, "coll c1");
    check_wr("coll c1", 1'b1, 3'd5, 16'h2222);
    idle("coll idle");
    check("coll R5", rf[5], 16'h2222);
    check("R6", rf[6], 16'h0666);

    // Fairness: both always valid, grants alternate 0,1,0,1,0,1.
    for (int i = 0; i < 6; i++) begin
      logic g0;
      g0 = (i % 2 == 0);
      step(1'b1, 3'd0, 16'h0A00 + 16'(i), 1'b1, 3'd7, 16'h0B00 + 16'(i),
           g0, !g0, $sformatf("fair %0d", i));
      check_wr($sformatf("fair %0d", i), 1'b1, g0 ? 3'd0 : 3'd7,
               g0 ? 16'h0A00 + 16'(i) : 16'h0B00 + 16'(i));
    end
    idle("fair idle");
    check("fair R0", rf[0], 16'h0A04);
    check("fair R7", rf[7], 16'h0B05);

    // Reset while an accepted write is being presented: it is lost.
    step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h4444, 1'b0, 1'b1, "abort");
    check_wr("abort pre", 1'b1, 3'd4, 16'h4444);
    req1_valid = 1'b0;
    #1 CLR = 1'b1;
    #1;
    check_wr("abort clr", 1'b0, 3'd0, 16'h0000);
    @(posedge CLK); #1;
    check("abort R4", rf[4], exp_r4);
    @(negedge CLK); CLR = 1'b0;
    // rr_ptr back at 0 (or sweep in progress holding readies low).
    step(1'b1, 3'd2, 16'h5555, 1'b1, 3'd3, 16'h6666,
         exp_ready_after, 1'b0, "post clr");
    idle("final idle");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
